// File: rtl/if_flow_ctrl.sv
// if_flow_ctrl
// Front-end sequencing controller for the IF stage and the IF/ID register.
// It merges ID data hazards, memory-stage stalls, instruction-memory wait
// states and EX-resolved branches into the fetch-stage controls. A small FSM
// keeps a branch redirect asserted until the fetch completes, then flushes
// wrong-path fetches for FLUSH_CYCLES more cycles.
//
// Parameters:
//   CNT_W        width of the saturating performance counters
//   FLUSH_CYCLES extra IF/ID flush cycles after a redirect completes (0-15)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   hazard       ID-stage data hazard, front end must hold
//   mem_stall    memory stage busy, front end holds and branches are deferred
//   br_valid     EX resolved a taken branch (held while mem_stall=1)
//   br_target    branch target
//   imem_ready   instruction memory returns the fetched word this cycle
//   clr_cnt      synchronous clear of both counters
//   freeze       hold PC and IF/ID
//   Branch_taken load PC from BranchAddr
//   BranchAddr   redirect target
//   flush        clear IF/ID to a bubble
//   id_flush     clear ID/EX to a bubble
//   stall_cnt    cycles with freeze=1, saturating
//   flush_cnt    accepted redirects, saturating
//   state        RUN=0, REDIRECT=1, SHADOW=2
module if_flow_ctrl #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             mem_stall,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    input  logic             imem_ready,
    input  logic             clr_cnt,
    output logic             freeze,
    output logic             Branch_taken,
    output logic [31:0]      BranchAddr,
    output logic             flush,
    output logic             id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_SHADOW   = 2'd2;

    localparam logic [3:0]       SH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      tgt_q,       tgt_d;
    logic [3:0]       sh_cnt_q,    sh_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic        accept;
    logic        freeze_c;
    logic        taken_c;
    logic [31:0] addr_c;
    logic        flush_c;
    logic        id_flush_c;

    // Control outputs and next-state logic. Once the fetched word arrives the
    // redirect either ends outright or hands over to the shadow flush.
    always_comb begin
        accept     = 1'b0;
        freeze_c   = 1'b0;
        taken_c    = 1'b0;
        addr_c     = tgt_q;
        flush_c    = 1'b0;
        id_flush_c = 1'b0;
        state_d    = state_q;
        tgt_d      = tgt_q;
        sh_cnt_d   = sh_cnt_q;

        case (state_q)
            ST_RUN: begin
                accept = br_valid & ~mem_stall;
                if (accept) begin
                    // A taken branch wins over a data hazard: the stalled
                    // instruction is on the wrong path anyway.
                    taken_c    = 1'b1;
                    addr_c     = br_target;
                    flush_c    = 1'b1;
                    id_flush_c = 1'b1;
                    tgt_d      = br_target;
                    if (!imem_ready) begin
                        state_d = ST_REDIRECT;
                    end else if (FLUSH_CYCLES > 0) begin
                        state_d  = ST_SHADOW;
                        sh_cnt_d = SH_INIT;
                    end
                end else begin
                    freeze_c = hazard | mem_stall | ~imem_ready;
                end
            end
            ST_REDIRECT: begin
                taken_c = 1'b1;
                flush_c = 1'b1;
                if (imem_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        state_d  = ST_SHADOW;
                        sh_cnt_d = SH_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_SHADOW: begin
                flush_c  = 1'b1;
                freeze_c = mem_stall;
                // A memory stall freezes the shadow count so every
                // wrong-path slot still gets flushed.
                if (!mem_stall) begin
                    sh_cnt_d = sh_cnt_q - 4'd1;
                    if (sh_cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset forces every control low straight away, even mid-redirect.
    assign freeze       = rst & freeze_c;
    assign Branch_taken = rst & taken_c;
    assign flush        = rst & flush_c;
    assign id_flush     = rst & id_flush_c;
    assign BranchAddr   = rst ? addr_c : 32'd0;

    // Saturating counters; a clear takes priority over any increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (freeze && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (accept && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            tgt_q       <= 32'd0;
            sh_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            sh_cnt_q    <= sh_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_if_flow_ctrl.sv
// tb_if_flow_ctrl
// Bench for if_flow_ctrl. Two instances share the same stimulus:
//   dut_a  CNT_W=4,  FLUSH_CYCLES=1 (counter saturation, single-cycle shadow)
//   dut_b  CNT_W=16, FLUSH_CYCLES=3 (longer shadow period)
// A behavioural model tracks "redirect pending" and "shadow slots left" for
// each instance and predicts every output each cycle.
module tb_if_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        mem_stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        imem_ready;
    logic        clr_cnt;

    logic [1:0]  freeze_o;
    logic [1:0]  taken_o;
    logic [1:0]  flush_o;
    logic [1:0]  idf_o;
    logic [31:0] addr_a, addr_b;
    logic [3:0]  stall_a, fcnt_a;
    logic [15:0] stall_b, fcnt_b;
    logic [1:0]  state_a, state_b;

    int total;
    int bad;

    if_flow_ctrl #(.CNT_W(4), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .hazard(hazard), .mem_stall(mem_stall),
        .br_valid(br_valid), .br_target(br_target), .imem_ready(imem_ready),
        .clr_cnt(clr_cnt), .freeze(freeze_o[0]), .Branch_taken(taken_o[0]),
        .BranchAddr(addr_a), .flush(flush_o[0]), .id_flush(idf_o[0]),
        .stall_cnt(stall_a), .flush_cnt(fcnt_a), .state(state_a)
    );

    if_flow_ctrl #(.CNT_W(16), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .hazard(hazard), .mem_stall(mem_stall),
        .br_valid(br_valid), .br_target(br_target), .imem_ready(imem_ready),
        .clr_cnt(clr_cnt), .freeze(freeze_o[1]), .Branch_taken(taken_o[1]),
        .BranchAddr(addr_b), .flush(flush_o[1]), .id_flush(idf_o[1]),
        .stall_cnt(stall_b), .flush_cnt(fcnt_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          pending;
        int          shadow_left;
        logic [31:0] tgt;
        int          stalls;
        int          redirects;
    } model_t;

    typedef struct {
        bit          freeze;
        bit          taken;
        bit          flush;
        bit          idf;
        bit          accept;
        logic [31:0] addr;
        int          st;
    } exp_t;

    model_t mdl [2];

    function automatic int flushCyclesOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cntMaxOf(input int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic model_t clearedModel();
        model_t m;
        m.pending     = 1'b0;
        m.shadow_left = 0;
        m.tgt         = 32'd0;
        m.stalls      = 0;
        m.redirects   = 0;
        return m;
    endfunction

    // Predict the combinational controls for the current model state.
    function automatic exp_t predict(input model_t m, input bit r, input bit hz,
                                     input bit ms, input bit bv,
                                     input logic [31:0] tgt, input bit ir);
        exp_t e;
        e.freeze = 0; e.taken = 0; e.flush = 0; e.idf = 0; e.accept = 0;
        e.addr   = m.tgt;
        e.st     = m.pending ? 1 : (m.shadow_left > 0 ? 2 : 0);
        if (!r) begin
            e.addr = 32'd0;
        end else if (m.pending) begin
            e.taken = 1;
            e.flush = 1;
        end else if (m.shadow_left > 0) begin
            e.flush  = 1;
            e.freeze = ms;
        end else if (bv && !ms) begin
            e.accept = 1;
            e.taken  = 1;
            e.flush  = 1;
            e.idf    = 1;
            e.addr   = tgt;
        end else begin
            e.freeze = hz || ms || !ir;
        end
        return e;
    endfunction

    // Advance the model by one rising edge with reset released.
    function automatic model_t advance(input model_t m, input exp_t e,
                                       input bit clr, input bit ms,
                                       input logic [31:0] tgt, input bit ir,
                                       input int fl, input int maxc);
        model_t n = m;
        if (clr) begin
            n.stalls    = 0;
            n.redirects = 0;
        end else begin
            if (e.freeze && n.stalls < maxc) n.stalls++;
            if (e.accept && n.redirects < maxc) n.redirects++;
        end
        if (m.pending) begin
            if (ir) begin
                n.pending     = 0;
                n.shadow_left = fl;
            end
        end else if (m.shadow_left > 0) begin
            if (!ms) n.shadow_left = m.shadow_left - 1;
        end else if (e.accept) begin
            n.tgt = tgt;
            if (!ir) n.pending = 1;
            else     n.shadow_left = fl;
        end
        return n;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic checkDut(input int k, input exp_t e);
        string p;
        p = (k == 0) ? "a" : "b";
        checkOutput({p, "_freeze"},   32'(freeze_o[k]), 32'(e.freeze));
        checkOutput({p, "_taken"},    32'(taken_o[k]),  32'(e.taken));
        checkOutput({p, "_flush"},    32'(flush_o[k]),  32'(e.flush));
        checkOutput({p, "_id_flush"}, 32'(idf_o[k]),    32'(e.idf));
        checkOutput({p, "_addr"},     (k == 0) ? addr_a : addr_b, e.addr);
        checkOutput({p, "_state"},    (k == 0) ? 32'(state_a) : 32'(state_b),
                    32'(e.st));
        checkOutput({p, "_stall_cnt"}, (k == 0) ? 32'(stall_a) : 32'(stall_b),
                    32'(mdl[k].stalls));
        checkOutput({p, "_flush_cnt"}, (k == 0) ? 32'(fcnt_a) : 32'(fcnt_b),
                    32'(mdl[k].redirects));
    endtask

    // One clock cycle: drive on the falling edge, check just after, then let
    // the rising edge advance both the DUTs and the model.
    task automatic applyStimulus(input bit r, input bit hz, input bit ms,
                                 input bit bv, input logic [31:0] tgt,
                                 input bit ir, input bit clr);
        exp_t e [2];
        @(negedge clk);
        rst        = r;
        hazard     = hz;
        mem_stall  = ms;
        br_valid   = bv;
        br_target  = tgt;
        imem_ready = ir;
        clr_cnt    = clr;
        if (!r) begin
            for (int k = 0; k < 2; k++) mdl[k] = clearedModel();
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            e[k] = predict(mdl[k], r, hz, ms, bv, tgt, ir);
            checkDut(k, e[k]);
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                mdl[k] = advance(mdl[k], e[k], clr, ms, tgt, ir,
                                 flushCyclesOf(k), cntMaxOf(k));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 32'h0, 1, 0);
    endtask

    initial begin
        bit          hold;
        bit          r, hz, ms, bv, ir, clr;
        logic [31:0] tgt;

        total = 0;
        bad   = 0;
        rst = 1'b0; hazard = 0; mem_stall = 0; br_valid = 0;
        br_target = 32'h0; imem_ready = 1; clr_cnt = 0;
        for (int k = 0; k < 2; k++) mdl[k] = clearedModel();

        applyStimulus(0, 1, 1, 1, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
        idle(1);

        // Three hazard cycles freeze the front end exactly three times.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 32'h0, 1, 0);
        #1;
        checkOutput("hazard_stall_cnt", 32'(stall_a), 32'd3);
        idle(1);

        // Branch with the fetch ready: one redirect cycle, one shadow cycle.
        applyStimulus(1, 0, 0, 1, 32'h0000_0100, 1, 0);
        #1;
        checkOutput("br100_shadow_state", 32'(state_a), 32'd2);
        idle(1);
        #1;
        checkOutput("br100_run_state", 32'(state_a), 32'd0);
        checkOutput("br100_flush_cnt", 32'(fcnt_a), 32'd1);
        idle(4);

        // Branch while the fetch is two cycles late.
        applyStimulus(1, 0, 0, 1, 32'h0000_0200, 0, 0);
        applyStimulus(1, 1, 1, 1, 32'h0000_0999, 0, 0);
        #1;
        checkOutput("br200_redirect_state", 32'(state_a), 32'd1);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 0);
        #1;
        checkOutput("br200_shadow_state", 32'(state_a), 32'd2);
        idle(5);

        // Branch deferred by two memory-stall cycles.
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        applyStimulus(1, 0, 1, 1, 32'h0000_0300, 1, 0);
        applyStimulus(1, 0, 1, 1, 32'h0000_0300, 1, 0);
        applyStimulus(1, 0, 0, 1, 32'h0000_0300, 1, 0);
        #1;
        checkOutput("defer_stall_cnt", 32'(stall_a), 32'd2);
        checkOutput("defer_flush_cnt", 32'(fcnt_a), 32'd1);
        idle(5);

        // Saturation and clear on the narrow counter.
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 32'h0, 1, 0);
        #1;
        checkOutput("sat_stall_cnt", 32'(stall_a), 32'd15);
        applyStimulus(1, 1, 0, 0, 32'h0, 1, 1);
        #1;
        checkOutput("clr_stall_cnt", 32'(stall_a), 32'd0);
        idle(2);

        // Reset pulsed while a redirect is outstanding.
        applyStimulus(1, 0, 0, 1, 32'h0000_0400, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("rst_state", 32'(state_a), 32'd0);
        checkOutput("rst_flush_cnt", 32'(fcnt_a), 32'd0);
        idle(2);

        // Randomized traffic; br_valid is held with its target while stalled.
        hold = 0;
        tgt  = 32'h0;
        bv   = 0;
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 199) != 0);
            hz  = ($urandom_range(0, 3) == 0);
            ms  = ($urandom_range(0, 4) == 0);
            ir  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            if (!hold) begin
                bv  = ($urandom_range(0, 4) == 0);
                tgt = $urandom;
            end
            applyStimulus(r, hz, ms, bv, tgt, ir, clr);
            hold = bv && ms && r;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
